// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
//   Initiator for one dualport_sram port (wr/rd/addr/din/dout). Takes single
//   read or write requests over a valid/ready handshake, pulses the SRAM strobe
//   for one cycle, and returns exactly one response per request. Only one
//   transaction is in flight at a time.
//
//   Optional feature (macro SRAM_WR_VERIFY_EN): each write is followed by a
//   readback of the same address. The response flags rsp_err when the
//   readback differs from the written data, and rsp_rdata carries the
//   readback. Without the macro, rsp_err is always 0.
//
// Parameters
//   DW      data width (matches SRAM din/dout)
//   AW      address width (matches SRAM addr)
//   RD_LAT  cycles from the edge that samples mem_rd=1 to valid mem_dout (1..4)
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata      request fields, registered on accept
//   rsp_valid/rsp_ready            response handshake (valid held until ready)
//   rsp_we/rsp_rdata/rsp_err       response fields
//   mem_wr/mem_rd/mem_addr/mem_din SRAM drive
//   mem_dout                       SRAM read data
//   busy                           high whenever not IDLE
// -----------------------------------------------------------------------------
module sram_access_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
`ifdef SRAM_WR_VERIFY_EN
    localparam logic [2:0] S_VRD   = 3'd4;
    localparam logic [2:0] S_VWAIT = 3'd5;
`endif

    // Wait counter is loaded with RD_LAT-1 on the edge that samples mem_rd,
    // so data is captured on edge (sample edge + RD_LAT).
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rsp_we_q, rsp_we_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
`ifdef SRAM_WR_VERIFY_EN
                    state_d = S_VRD;
`else
                    state_d     = S_RESP;
                    rsp_we_d    = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d     = S_RESP;
                    rsp_we_d    = 1'b0;
                    rsp_rdata_d = mem_dout;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef SRAM_WR_VERIFY_EN
            S_VRD: begin
                state_d = S_VWAIT;
                cnt_d   = LAT_M1;
            end
            S_VWAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d     = S_RESP;
                    rsp_we_d    = 1'b1;
                    rsp_rdata_d = mem_dout;
                    rsp_err_d   = (mem_dout != wdata_q);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_wr    = (state_q == S_ISSUE) && we_q;
`ifdef SRAM_WR_VERIFY_EN
    assign mem_rd    = ((state_q == S_ISSUE) && !we_q) || (state_q == S_VRD);
`else
    assign mem_rd    = (state_q == S_ISSUE) && !we_q;
`endif
    assign mem_addr  = addr_q;
    assign mem_din   = wdata_q;
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_access_ctrl
//   Directed bench for sram_access_ctrl. DUT A uses RD_LAT=1, DUT B uses
//   RD_LAT=3; each has its own behavioural SRAM. Expected responses are pushed
//   to a scoreboard queue when a request is accepted and popped when the
//   response appears. Honors SRAM_WR_VERIFY_EN when the build defines it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam logic [DW-1:0] POISON = 32'hDEAD_BEEF;
`ifdef SRAM_WR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WR_LAT_A = VERIFY ? 3 : 1;
    localparam int WR_LAT_B = VERIFY ? 5 : 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // DUT A (RD_LAT=1)
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr, mem_rd, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    // DUT B (RD_LAT=3)
    logic          req_valid_b, req_ready_b, req_we_b;
    logic [AW-1:0] req_addr_b;
    logic [DW-1:0] req_wdata_b;
    logic          rsp_valid_b, rsp_ready_b, rsp_we_b, rsp_err_b;
    logic [DW-1:0] rsp_rdata_b;
    logic          mem_wr_b, mem_rd_b, busy_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_din_b, mem_dout_b;

    sram_access_ctrl #(.DW(DW), .AW(AW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    sram_access_ctrl #(.DW(DW), .AW(AW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_we(rsp_we_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
        .mem_din(mem_din_b), .mem_dout(mem_dout_b), .busy(busy_b)
    );

    // SRAM A: registered read, latency 1; flip_bit0 corrupts stored data.
    logic [DW-1:0] sram_a [0:7];
    logic          flip_bit0 = 1'b0;
    always @(posedge clk) begin
        if (mem_wr) sram_a[mem_addr] <= mem_din ^ {{(DW-1){1'b0}}, flip_bit0};
        mem_dout <= mem_rd ? sram_a[mem_addr] : POISON;
    end

    // SRAM B: read latency 3 through a shift pipe.
    logic [DW-1:0] sram_b [0:7];
    logic [DW-1:0] pipe_b [0:2];
    always @(posedge clk) begin
        if (mem_wr_b) sram_b[mem_addr_b] <= mem_din_b;
        pipe_b[0] <= mem_rd_b ? sram_b[mem_addr_b] : POISON;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_dout_b = pipe_b[2];

    // Strobe monitor on DUT A
    int wr_strobes = 0;
    int rd_strobes = 0;
    bit both_hi = 1'b0;
    always @(posedge clk) begin
        if (mem_wr) wr_strobes <= wr_strobes + 1;
        if (mem_rd) rd_strobes <= rd_strobes + 1;
        if (mem_wr && mem_rd) both_hi <= 1'b1;
    end

    typedef struct {
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] shadow [0:7];
    int n_assert = 0;
    int n_fail = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    longint last_e0 = 0;
    longint last_gap = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for accept, check the ISSUE cycle, push expectation.
    task automatic send_req(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input string tag);
        exp_t e;
        logic [DW-1:0] stored;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        chk({tag, ".req_ready"}, DW'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_gap = $time - last_e0;
        last_e0  = $time;
        chk({tag, ".mem_wr"},   DW'(mem_wr), DW'(we));
        chk({tag, ".mem_rd"},   DW'(mem_rd), DW'(!we));
        chk({tag, ".mem_addr"}, DW'(mem_addr), DW'(addr));
        chk({tag, ".mem_din"},  mem_din, data);
        chk({tag, ".busy"},     DW'(busy), 1);
        e.we = we;
        if (we) begin
            stored       = data ^ {{(DW-1){1'b0}}, flip_bit0};
            shadow[addr] = stored;
            e.rdata      = VERIFY ? stored : '0;
            e.err        = VERIFY && flip_bit0;
            e.lat        = WR_LAT_A;
            exp_wr++;
            if (VERIFY) exp_rd++;
        end else begin
            e.rdata = shadow[addr];
            e.err   = 1'b0;
            e.lat   = 2;
            exp_rd++;
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for the response, compare against the scoreboard, then
    // optionally stall rsp_ready for 'hold' cycles before the handshake.
    task automatic wait_rsp(input int hold, input string tag);
        exp_t e;
        int lat;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, DW'(lat), DW'(e.lat));
        chk({tag, ".rsp_we"},  DW'(rsp_we), DW'(e.we));
        chk({tag, ".rdata"},   rsp_rdata, e.rdata);
        chk({tag, ".rsp_err"}, DW'(rsp_err), DW'(e.err));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                // A competing request while busy must be ignored.
                req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 32'hBAD0_BAD0;
            end
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, DW'(rsp_valid), 1);
            chk({tag, ".hold_rdata"}, rsp_rdata, e.rdata);
            chk({tag, ".hold_ready"}, DW'(req_ready), 0);
            chk({tag, ".hold_busy"},  DW'(busy), 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".rsp_done"}, DW'(rsp_valid), 0);
        chk({tag, ".idle_rdy"}, DW'(req_ready), 1);
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int hold, input string tag);
        rsp_ready = (hold == 0);
        send_req(we, addr, data, tag);
        wait_rsp(hold, tag);
    endtask

    task automatic txn_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int exp_lat, input logic [DW-1:0] exp_rdata, input string tag);
        int lat;
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = data;
        chk({tag, ".req_ready"}, DW'(req_ready_b), 1);
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        chk({tag, ".busy"}, DW'(busy_b), 1);
        lat = 0;
        while (rsp_valid_b !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, DW'(lat), DW'(exp_lat));
        chk({tag, ".rsp_we"},  DW'(rsp_we_b), DW'(we));
        chk({tag, ".rdata"},   rsp_rdata_b, exp_rdata);
        chk({tag, ".rsp_err"}, DW'(rsp_err_b), 0);
        @(posedge clk); #1;
        chk({tag, ".rsp_done"}, DW'(rsp_valid_b), 0);
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) shadow[i] = '0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst.req_ready", DW'(req_ready), 1);
        chk("rst.busy",      DW'(busy), 0);
        chk("rst.rsp_valid", DW'(rsp_valid), 0);
        chk("rst.mem_wr",    DW'(mem_wr), 0);
        chk("rst.mem_rd",    DW'(mem_rd), 0);
        chk("rst.mem_addr",  DW'(mem_addr), 0);
        chk("rst.mem_din",   mem_din, 0);
        chk("rst.rsp_we",    DW'(rsp_we), 0);
        chk("rst.rsp_rdata", rsp_rdata, 0);
        chk("rst.rsp_err",   DW'(rsp_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: write then read at address 0
        txn(1'b1, 3'd0, 32'h0000_00ff, 0, "T1.wr");
        txn(1'b0, 3'd0, 32'h5555_0000, 0, "T1.rd");

        // T2: three writes, read back out of order; check write throughput
        txn(1'b1, 3'd1, 32'h0011_ffff, 0, "T2.wr1");
        txn(1'b1, 3'd2, 32'h0011_abcd, 0, "T2.wr2");
        chk("T2.wr_gap_cycles", DW'(last_gap / 10), DW'(WR_LAT_A + 2));
        txn(1'b1, 3'd3, 32'h0011_0000, 0, "T2.wr3");
        txn(1'b0, 3'd1, 32'h5555_0001, 0, "T2.rd1");
        txn(1'b0, 3'd3, 32'h5555_0003, 0, "T2.rd3");
        txn(1'b0, 3'd2, 32'h5555_0002, 0, "T2.rd2");

        // T3: read with rsp_ready withheld for 5 cycles
        txn(1'b0, 3'd3, 32'h5555_0013, 5, "T3.rd");

        // T4: reset during WAIT of a read at address 2
        rsp_ready = 1'b1;
        send_req(1'b0, 3'd2, 32'h5555_0042, "T4.rd");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("T4.mem_rd",    DW'(mem_rd), 0);
        chk("T4.mem_wr",    DW'(mem_wr), 0);
        chk("T4.mem_addr",  DW'(mem_addr), 0);
        chk("T4.mem_din",   mem_din, 0);
        chk("T4.rsp_valid", DW'(rsp_valid), 0);
        chk("T4.rsp_rdata", rsp_rdata, 0);
        chk("T4.busy",      DW'(busy), 0);
        chk("T4.req_ready", DW'(req_ready), 1);
        void'(sb.pop_front());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("T4.no_rsp", DW'(rsp_valid), 0);
        end
        chk("T4.ready_after", DW'(req_ready), 1);

        // T5: RD_LAT=3 instance
        txn_b(1'b1, 3'd3, 32'hA5A5_0003, WR_LAT_B, VERIFY ? 32'hA5A5_0003 : 32'h0, "T5.wr");
        txn_b(1'b0, 3'd3, 32'h0, 4, 32'hA5A5_0003, "T5.rd");

`ifdef SRAM_WR_VERIFY_EN
        // T6: corrupted write flagged, clean write not flagged
        flip_bit0 = 1'b1;
        txn(1'b1, 3'd1, 32'h0011_ffff, 0, "T6.flip");
        flip_bit0 = 1'b0;
        txn(1'b1, 3'd4, 32'h0022_1234, 0, "T6.clean");
        txn(1'b0, 3'd4, 32'h5555_0004, 0, "T6.rd");
`endif

        @(posedge clk); #1;
        chk("strobe.never_both", DW'(both_hi), 0);
        chk("strobe.wr_count", DW'(wr_strobes), DW'(exp_wr));
        chk("strobe.rd_count", DW'(rd_strobes), DW'(exp_rd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
